// File: rtl/multi_delay_timer.sv
// multi_delay_timer: multi-channel programmable delay / pulse generator.
// Each channel counts enabled ticks and emits a one-cycle sig pulse every
// per+1 ticks, in periodic or one-shot mode, with an in-window flag and a
// sticky error for a counter left above a freshly shortened period.
// Optional feature macro: PRESCALE_EN (adds PRE_DIV and a shared prescaler).

module multi_delay_timer #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned CBITS     = 14,
    parameter int unsigned DEFAULT_N = 12500
`ifdef PRESCALE_EN
    ,
    parameter int unsigned PRE_DIV   = 1
`endif
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NCH-1:0]                            en,
    input  logic                                      cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  cfg_ch,
    input  logic [CBITS-1:0]                          cfg_per,
    input  logic                                      cfg_oneshot,
    input  logic [NCH-1:0]                            err_clr,
    output logic [NCH-1:0]                            sig,
    output logic [NCH-1:0]                            flg,
    output logic [NCH-1:0]                            err,
    output logic [NCH-1:0]                            done
);

    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    // Per-channel control states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [NCH-1:0][CBITS-1:0] cnt_q;
    logic [NCH-1:0][CBITS-1:0] cnt_d;
    logic [NCH-1:0][CBITS-1:0] per_q;
    logic [NCH-1:0][CBITS-1:0] per_d;
    logic [NCH-1:0][1:0]       st_q;
    logic [NCH-1:0][1:0]       st_d;
    logic [NCH-1:0]            os_q;
    logic [NCH-1:0]            os_d;
    logic [NCH-1:0]            sig_d;
    logic [NCH-1:0]            flg_d;
    logic [NCH-1:0]            err_d;
    logic [NCH-1:0]            done_d;
    logic [NCH-1:0]            cfg_sel;
    logic                      tick;

`ifdef PRESCALE_EN
    localparam int unsigned PBITS = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

    logic [PBITS-1:0] pre_cnt;

    // Shared free-running prescaler; tick marks the last clock of each PRE_DIV window
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PBITS'(PRE_DIV - 1)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PBITS'(1);
        end
    end

    assign tick = (pre_cnt == PBITS'(PRE_DIV - 1));
`else
    assign tick = 1'b1;
`endif

    // Decode the configuration write into a one-hot channel select; out-of-range writes are dropped
    always_comb begin
        cfg_sel = '0;
        if (cfg_we && (32'(cfg_ch) < NCH)) begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_ch == CHW'(i)) begin
                    cfg_sel[i] = 1'b1;
                end
            end
        end
    end

    // Next-state and next-output logic for every channel
    always_comb begin
        cnt_d  = cnt_q;
        per_d  = per_q;
        os_d   = os_q;
        st_d   = st_q;
        sig_d  = '0;
        flg_d  = '0;
        err_d  = err & ~err_clr;
        done_d = '0;

        for (int i = 0; i < NCH; i++) begin
            // New period/mode only affects comparisons from the next cycle on
            if (cfg_sel[i]) begin
                per_d[i] = cfg_per;
                os_d[i]  = cfg_oneshot;
            end

            if (st_q[i] == ST_HALT) begin
                // Halted one-shot: counter parked at zero until re-armed by a write
                cnt_d[i] = '0;
                if (cfg_sel[i]) begin
                    st_d[i] = en[i] ? ST_RUN : ST_IDLE;
                end
            end else begin
                st_d[i] = en[i] ? ST_RUN : ST_IDLE;
                if (en[i] && tick) begin
                    if (cnt_q[i] == per_q[i]) begin
                        sig_d[i] = 1'b1;
                        cnt_d[i] = '0;
                        if (os_q[i]) begin
                            st_d[i] = ST_HALT;
                        end
                    end else if (cnt_q[i] > per_q[i]) begin
                        // Period was shortened below the running count: restart and flag it
                        cnt_d[i] = '0;
                        err_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CBITS'(1);
                    end
                end
            end

            flg_d[i]  = (cnt_d[i] <= per_d[i]);
            done_d[i] = (st_d[i] == ST_HALT);
        end
    end

    // Channel state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                per_q[i] <= CBITS'(DEFAULT_N);
                st_q[i]  <= ST_IDLE;
            end
            os_q <= '0;
            sig  <= '0;
            flg  <= '1;
            err  <= '0;
            done <= '0;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
            st_q  <= st_d;
            os_q  <= os_d;
            sig   <= sig_d;
            flg   <= flg_d;
            err   <= err_d;
            done  <= done_d;
        end
    end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Testbench for multi_delay_timer (NCH=2, CBITS=4, DEFAULT_N=5).
// Vector table with a scoreboard queue, plus a hand-written one-shot sequence.

module tb_multi_delay_timer;

    logic       clk;
    logic       rst;
    logic [1:0] en;
    logic       cfg_we;
    logic [0:0] cfg_ch;
    logic [3:0] cfg_per;
    logic       cfg_oneshot;
    logic [1:0] err_clr;
    logic [1:0] sig;
    logic [1:0] flg;
    logic [1:0] err;
    logic [1:0] done;

    typedef struct {
        string      tag;
        logic       rst;
        logic [1:0] en;
        logic       we;
        logic       ch;
        logic [3:0] per;
        logic       os;
        logic [1:0] clr;
        logic [1:0] sig;
        logic [1:0] flg;
        logic [1:0] err;
        logic [1:0] done;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] exp_q[$];
    int         checks;
    int         failures;

    multi_delay_timer #(
        .NCH       (2),
        .CBITS     (4),
        .DEFAULT_N (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_per     (cfg_per),
        .cfg_oneshot (cfg_oneshot),
        .err_clr     (err_clr),
        .sig         (sig),
        .flg         (flg),
        .err         (err),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic void add(input string tag, input logic r, input logic [1:0] e,
                                input logic we, input logic ch, input logic [3:0] per,
                                input logic os, input logic [1:0] clr, input logic [1:0] xs,
                                input logic [1:0] xf, input logic [1:0] xe, input logic [1:0] xd);
        vec_t v;
        v.tag = tag; v.rst = r; v.en = e; v.we = we; v.ch = ch; v.per = per;
        v.os = os; v.clr = clr; v.sig = xs; v.flg = xf; v.err = xe; v.done = xd;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        vec_t       v;
        logic [7:0] e;
        int         lat;
        int         pulses;

        checks = 0;
        failures = 0;
        rst = 1'b1; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_per = '0;
        cfg_oneshot = 1'b0; err_clr = '0;

        // Reset, then ch0 periodic at the default period of 5
        add("rst", 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        add("rst", 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        for (int k = 1; k <= 18; k++)
            add("A_per", 0, 2'b01, 0, 0, 0, 0, 2'b00, (k % 6 == 0) ? 2'b01 : 2'b00, 2'b11, 2'b00, 2'b00);

        // ch1 one-shot with period 2, halt, then re-arm as periodic
        add("B_wr", 0, 2'b00, 1, 1, 4'd2, 1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        for (int k = 1; k <= 3; k++)
            add("B_os", 0, 2'b10, 0, 0, 0, 0, 2'b00, (k == 3) ? 2'b10 : 2'b00, 2'b11, 2'b00,
                (k == 3) ? 2'b10 : 2'b00);
        for (int k = 1; k <= 20; k++)
            add("B_halt", 0, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10);
        add("B_rearm", 0, 2'b10, 1, 1, 4'd2, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        for (int k = 1; k <= 6; k++)
            add("B_run", 0, 2'b10, 0, 0, 0, 0, 2'b00, (k % 3 == 0) ? 2'b10 : 2'b00, 2'b11, 2'b00, 2'b00);

        // Shorten ch0 period below its count: old period decides this cycle, error next
        for (int k = 1; k <= 4; k++)
            add("C_cnt", 0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        add("C_wr",     0, 2'b01, 1, 0, 4'd1, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        add("C_err",    0, 2'b01, 0, 0, 0,    0, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00);
        add("C_stk",    0, 2'b00, 0, 0, 0,    0, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00);
        add("C_clr",    0, 2'b00, 0, 0, 0,    0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00);
        add("C_c1",     0, 2'b01, 0, 0, 0,    0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        add("C_wr0",    0, 2'b00, 1, 0, 4'd0, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        add("C_setclr", 0, 2'b01, 0, 0, 0,    0, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00);
        add("C_clr2",   0, 2'b00, 0, 0, 0,    0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00);
        for (int k = 1; k <= 3; k++)
            add("C_p0", 0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00);

        // ch0 period 5 with a 3-cycle enable gap mid-count
        add("D_wr", 0, 2'b00, 1, 0, 4'd5, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        for (int k = 1; k <= 2; k++)
            add("D_on", 0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        for (int k = 1; k <= 3; k++)
            add("D_gap", 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        for (int k = 1; k <= 4; k++)
            add("D_res", 0, 2'b01, 0, 0, 0, 0, 2'b00, (k == 4) ? 2'b01 : 2'b00, 2'b11, 2'b00, 2'b00);

        // ch1 period 0 pulses every cycle, then reset mid-run restores period 5 on both
        add("E_wr", 0, 2'b00, 1, 1, 4'd0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        for (int k = 1; k <= 4; k++)
            add("E_p0", 0, 2'b11, 0, 0, 0, 0, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00);
        add("E_rst", 1, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        for (int k = 1; k <= 6; k++)
            add("E_def", 0, 2'b11, 0, 0, 0, 0, 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b11, 2'b00, 2'b00);

        // Apply each vector; expectation queued at drive time, popped once the edge has passed
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            rst = v.rst; en = v.en; cfg_we = v.we; cfg_ch = v.ch; cfg_per = v.per;
            cfg_oneshot = v.os; err_clr = v.clr;
            exp_q.push_back({v.sig, v.flg, v.err, v.done});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s[%0d] {sig,flg,err,done}", v.tag, i), {sig, flg, err, done}, e);
        end

        // One-shot on ch1 with period 3: bounded wait for done, then verify it stays quiet
        rst = 1'b0; en = 2'b00; err_clr = '0;
        cfg_we = 1'b1; cfg_ch = 1'b1; cfg_per = 4'd3; cfg_oneshot = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        en = 2'b10;
        lat = 0;
        pulses = 0;
        while (done[1] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (sig[1] === 1'b1) pulses++;
        end
        check("F_latency", 8'(lat), 8'd4);
        check("F_sig_at_done", {6'd0, sig}, 8'b10);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (sig[1] === 1'b1) pulses++;
        end
        check("F_single_pulse", 8'(pulses), 8'd1);
        check("F_still_done", {6'd0, done}, 8'b10);
        cfg_we = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        check("F_rearm_done", {6'd0, done}, 8'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
